// File: rtl/mtm_alu_pkg.sv
// Shared constants, types and CRC helpers for the serial ALU.
// Every frame-format number used by the receiver, ALU and serializer lives here.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  localparam int PKT_BITS      = 11;
  localparam int PAYLOAD_BITS  = 8;
  localparam int REQ_DATA_PKTS = 8;
  localparam int RSP_PKTS      = 5;
  localparam int ERR_PKTS      = 1;

  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 0;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  // Serial LFSR form of x^4+x+1, fed MSB first from a zero seed.
  function automatic logic [3:0] crc4_68(input logic [67:0] msg);
    logic [3:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ msg[i];
      crc = {crc[2], crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  // Serial LFSR form of x^3+x+1, fed MSB first from a zero seed.
  function automatic logic [2:0] crc3_37(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic [PKT_BITS-1:0] make_pkt(input logic ptype,
                                                   input logic [PAYLOAD_BITS-1:0] payload);
    return {1'b0, ptype, payload, 1'b1};
  endfunction

endpackage

// File: rtl/mtm_alu_if.sv
// Pin-level serial pair of the ALU: request line in, response line out.
interface mtm_alu_if;
  logic sin;
  logic sout;

  modport master (output sin, input  sout);
  modport slave  (input  sin, output sout);
endinterface

// File: rtl/mtm_alu_serializer.sv
// Shifts a list of 1 or 5 eleven-bit packets out MSB first, back to back.
// sout rests at 1 whenever nothing is being sent.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [2:0]                         count,
  input  logic [RSP_PKTS-1:0][PKT_BITS-1:0]  words,
  output logic                               sout,
  output logic                               busy,
  output logic                               done
);

  localparam int SEQ_BITS = RSP_PKTS * PKT_BITS;

  logic [SEQ_BITS-1:0] seq;
  logic [SEQ_BITS-1:0] shreg;
  logic [5:0]          bits_left;
  logic [5:0]          total_bits;

  // words[0] goes first; a single-packet list simply stops after 11 bits.
  assign seq        = {words[0], words[1], words[2], words[3], words[4]};
  assign total_bits = 6'(count) * 6'(PKT_BITS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg     <= '0;
      bits_left <= '0;
      sout      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        sout      <= seq[SEQ_BITS-1];
        shreg     <= seq << 1;
        bits_left <= total_bits - 6'd1;
        busy      <= 1'b1;
      end else if (busy) begin
        if (bits_left != 6'd0) begin
          sout      <= shreg[SEQ_BITS-1];
          shreg     <= shreg << 1;
          bits_left <= bits_left - 6'd1;
        end else begin
          sout <= 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mtm_alu.sv
// Serial ALU top: receives B, A and a command packet, checks the frame,
// computes the result and hands a response packet list to the serializer.
module mtm_alu
  import mtm_alu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mtm_alu_if.slave bus
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RX_BITS    = 2'd1;
  localparam logic [1:0] ST_CHECK_STOP = 2'd2;
  localparam logic [1:0] ST_WAIT_CMD   = 2'd3;

  logic [1:0]  rx_state;
  logic [3:0]  bit_cnt;
  logic [8:0]  rx_shift;
  logic [3:0]  data_cnt;
  logic        stop_err;
  logic [63:0] operands;
  logic        resp_active;
  logic        calc_pending;
  logic [2:0]  frame_op;
  logic [2:0]  frame_err;

  logic                              tx_start;
  logic [2:0]                        tx_count;
  logic [RSP_PKTS-1:0][PKT_BITS-1:0] tx_words;
  logic                              ser_busy;
  logic                              ser_done;
  logic                              ser_sout;

  logic       pkt_type;
  logic [7:0] pkt_payload;
  logic [2:0] rx_op;
  logic [3:0] rx_crc;
  logic       rx_armed;
  logic       err_data;
  logic       err_crc;
  logic       err_op;

  assign pkt_type    = rx_shift[8];
  assign pkt_payload = rx_shift[7:0];
  assign rx_op       = pkt_payload[6:4];
  assign rx_crc      = pkt_payload[3:0];
  assign rx_armed    = !resp_active && !ser_busy;

  // Only the highest-priority error survives; the current sin is the CMD stop bit.
  always_comb begin
    err_data = (data_cnt != 4'(REQ_DATA_PKTS)) || stop_err || !bus.sin;
    err_crc  = !err_data && (crc4_68({operands, 1'b1, rx_op}) != rx_crc);
    err_op   = !err_data && !err_crc && !op_valid(rx_op);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state     <= ST_IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      data_cnt     <= '0;
      stop_err     <= 1'b0;
      operands     <= '0;
      resp_active  <= 1'b0;
      calc_pending <= 1'b0;
      frame_op     <= '0;
      frame_err    <= '0;
    end else begin
      calc_pending <= 1'b0;
      if (ser_done) begin
        resp_active <= 1'b0;
      end
      case (rx_state)
        ST_IDLE, ST_WAIT_CMD: begin
          if (!bus.sin && (rx_state == ST_WAIT_CMD || rx_armed)) begin
            rx_state <= ST_RX_BITS;
            bit_cnt  <= '0;
          end
        end
        ST_RX_BITS: begin
          rx_shift <= {rx_shift[7:0], bus.sin};
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            rx_state <= ST_CHECK_STOP;
          end
        end
        ST_CHECK_STOP: begin
          if (pkt_type == PKT_DATA) begin
            // Operands shift in so the last eight bytes always form {B, A}.
            operands <= {operands[55:0], pkt_payload};
            if (data_cnt != 4'hF) begin
              data_cnt <= data_cnt + 4'd1;
            end
            stop_err <= stop_err | !bus.sin;
            rx_state <= ST_WAIT_CMD;
          end else begin
            frame_op                <= rx_op;
            frame_err[ERR_DATA_BIT] <= err_data;
            frame_err[ERR_CRC_BIT]  <= err_crc;
            frame_err[ERR_OP_BIT]   <= err_op;
            calc_pending            <= 1'b1;
            resp_active             <= 1'b1;
            data_cnt                <= '0;
            stop_err                <= 1'b0;
            rx_state                <= ST_IDLE;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  logic [31:0] op_b;
  logic [31:0] op_a;
  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] alu_c;
  logic        carry;
  logic        ovf;
  logic [3:0]  flags;
  logic [2:0]  crc3;
  logic [7:0]  err_payload;

  assign op_b = operands[63:32];
  assign op_a = operands[31:0];
  assign sum  = {1'b0, op_b} + {1'b0, op_a};
  assign diff = {1'b0, op_b} - {1'b0, op_a};

  // diff[32] is the unsigned borrow, reported as Carry for SUB.
  always_comb begin
    alu_c = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (frame_op)
      OP_AND: alu_c = op_b & op_a;
      OP_OR:  alu_c = op_b | op_a;
      OP_ADD: begin
        alu_c = sum[31:0];
        carry = sum[32];
        ovf   = (op_b[31] == op_a[31]) && (alu_c[31] != op_b[31]);
      end
      OP_SUB: begin
        alu_c = diff[31:0];
        carry = diff[32];
        ovf   = (op_b[31] != op_a[31]) && (alu_c[31] != op_b[31]);
      end
      default: ;
    endcase
    flags             = '0;
    flags[FLAG_CARRY] = carry;
    flags[FLAG_OVF]   = ovf;
    flags[FLAG_ZERO]  = (alu_c == 32'd0);
    flags[FLAG_NEG]   = alu_c[31];
  end

  assign crc3        = crc3_37({alu_c, 1'b0, flags});
  assign err_payload = {1'b1, frame_err, frame_err, ^{1'b1, frame_err, frame_err}};

  // One registered stage between the CMD stop bit and the serializer load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_count <= '0;
      tx_words <= '0;
    end else begin
      tx_start <= calc_pending;
      if (calc_pending) begin
        if (|frame_err) begin
          tx_count    <= 3'(ERR_PKTS);
          tx_words    <= '0;
          tx_words[0] <= make_pkt(PKT_CMD, err_payload);
        end else begin
          tx_count    <= 3'(RSP_PKTS);
          tx_words[0] <= make_pkt(PKT_DATA, alu_c[31:24]);
          tx_words[1] <= make_pkt(PKT_DATA, alu_c[23:16]);
          tx_words[2] <= make_pkt(PKT_DATA, alu_c[15:8]);
          tx_words[3] <= make_pkt(PKT_DATA, alu_c[7:0]);
          tx_words[4] <= make_pkt(PKT_CMD, {1'b0, flags, crc3});
        end
      end
    end
  end

  mtm_alu_serializer u_serializer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .count (tx_count),
    .words (tx_words),
    .sout  (ser_sout),
    .busy  (ser_busy),
    .done  (ser_done)
  );

  assign bus.sout = ser_sout;

endmodule

// File: tb/tb_mtm_alu.sv
// Scoreboard bench for mtm_alu: frames are driven on sin, expected responses
// queued from a reference model, and a monitor decodes sout independently.
module tb_mtm_alu;
  import mtm_alu_pkg::*;

  typedef struct {
    int                 n_pkts;
    logic [4:0][10:0]   words;
    longint             stop_cyc;
    int                 id;
  } exp_t;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic   clk;
  logic   rst_n;
  longint cyc;
  int     errors;
  int     checks;
  int     frame_id;
  longint last_stop_cyc;
  bit     mon_en;
  bit     mon_busy;
  exp_t   exp_q[$];

  mtm_alu_if bus();

  mtm_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string what, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", what, actual, expected);
    end
  endtask

  // Reference CRCs by polynomial long division of msg * x^n.
  function automatic logic [3:0] ref_crc4(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_crc3(input logic [36:0] msg);
    logic [39:0] r;
    r = {msg, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic exp_t model(input logic [31:0] b, input logic [31:0] a,
                                 input logic [2:0] op, input logic [3:0] crc_sent,
                                 input int n_data, input bit bad_stop);
    exp_t            e;
    bit              ed, ec, eo, carry, ovf;
    logic [31:0]     c;
    logic [3:0]      flags;
    logic [7:0]      pl;
    longint          sres;
    longint unsigned ures;
    e.n_pkts = 0;
    e.words = '0;
    e.stop_cyc = 0;
    e.id = 0;
    ed = (n_data != 8) || bad_stop;
    ec = !ed && (crc_sent != ref_crc4({b, a, 1'b1, op}));
    eo = !ed && !ec && !(op inside {3'b000, 3'b001, 3'b100, 3'b101});
    if (ed || ec || eo) begin
      pl = {1'b1, ed, ec, eo, ed, ec, eo, 1'b0};
      pl[0] = ($countones(pl[7:1]) % 2 == 1);
      e.n_pkts = 1;
      e.words[0] = {1'b0, 1'b1, pl, 1'b1};
      return e;
    end
    carry = 1'b0;
    ovf = 1'b0;
    c = '0;
    sres = 0;
    case (op)
      3'b000: c = b & a;
      3'b001: c = b | a;
      3'b100: begin
        ures = {32'd0, b} + {32'd0, a};
        c = 32'(ures);
        carry = (ures > 64'hFFFF_FFFF);
        sres = longint'($signed(b)) + longint'($signed(a));
        ovf = (sres > SMAX) || (sres < SMIN);
      end
      default: begin
        c = b - a;
        carry = (b < a);
        sres = longint'($signed(b)) - longint'($signed(a));
        ovf = (sres > SMAX) || (sres < SMIN);
      end
    endcase
    flags = {carry, ovf, c == 32'd0, c[31]};
    e.n_pkts = 5;
    for (int i = 0; i < 4; i++)
      e.words[i] = {2'b00, c[31 - 8*i -: 8], 1'b1};
    e.words[4] = {1'b0, 1'b1, 1'b0, flags, ref_crc3({c, 1'b0, flags}), 1'b1};
    return e;
  endfunction

  task automatic send_bit(input logic b);
    @(posedge clk);
    #1 bus.sin = b;
  endtask

  task automatic send_packet(input logic ptype, input logic [7:0] pl, input logic stop);
    send_bit(1'b0);
    send_bit(ptype);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
    last_stop_cyc = cyc + 1;
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] a,
                               input logic [2:0] op, input logic [3:0] crc_flip,
                               input int n_data, input int bad_stop_pkt, input bit expect_rsp);
    logic [63:0] ba;
    logic [7:0]  byt;
    logic [3:0]  crc;
    exp_t        e;
    ba = {b, a};
    crc = ref_crc4({b, a, 1'b1, op}) ^ crc_flip;
    for (int i = 0; i < n_data; i++) begin
      if (i < 8) byt = ba[63 - 8*i -: 8];
      else       byt = 8'($urandom);
      send_packet(PKT_DATA, byt, (i == bad_stop_pkt) ? 1'b0 : 1'b1);
    end
    send_packet(PKT_CMD, {1'b0, op, crc}, 1'b1);
    if (expect_rsp) begin
      e = model(b, a, op, crc, n_data, bad_stop_pkt >= 0 && bad_stop_pkt < n_data);
      e.stop_cyc = last_stop_cyc;
      e.id = frame_id;
      exp_q.push_back(e);
    end
    frame_id++;
  endtask

  task automatic wait_response_done();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || mon_busy) && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    checkOutput("response_timeout", 32'(budget < 400), 32'd1);
    if (budget >= 400) exp_q.delete();
    repeat (4) @(posedge clk);
  endtask

  // Monitor: decodes every response on sout and checks it against the queue head.
  initial begin : monitor
    exp_t        e;
    logic [10:0] got;
    int          quiet;
    mon_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && bus.sout === 1'b0) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_response", 32'd1, 32'd0);
          quiet = 0;
          for (int t = 0; t < 200 && quiet < 12; t++) begin
            @(negedge clk);
            quiet = (bus.sout === 1'b1) ? quiet + 1 : 0;
          end
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("latency_f%0d", e.id), 32'(cyc - e.stop_cyc), 32'd2);
          for (int p = 0; p < e.n_pkts; p++) begin
            for (int k = 10; k >= 0; k--) begin
              if (!(p == 0 && k == 10)) @(negedge clk);
              got[k] = bus.sout;
            end
            checkOutput($sformatf("pkt%0d_f%0d", p, e.id), 32'(got), 32'(e.words[p]));
          end
          @(negedge clk);
          checkOutput($sformatf("idle_after_f%0d", e.id), 32'(bus.sout), 32'd1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #800000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    logic [31:0] rb, ra;
    logic [2:0]  rop;
    logic [3:0]  rflip;
    longint      k;
    bit          ok;
    errors = 0;
    checks = 0;
    frame_id = 0;
    last_stop_cyc = 0;
    mon_en = 1'b1;
    bus.sin = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_sout", 32'(bus.sout), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] directed frames");
    applyStimulus(32'h2, 32'h1, 3'b100, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h0, 32'h1, 3'b101, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h7FFFFFFF, 32'h1, 3'b100, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'hF0F0F0F0, 32'h0F0F0F0F, 3'b000, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h12345678, 32'h0F0F0000, 3'b001, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'hFFFFFFFF, 32'h1, 3'b100, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h80000000, 32'h1, 3'b101, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h11, 32'h22, 3'b010, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h2, 32'h1, 3'b100, 4'h5, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'hA5A5A5A5, 32'h1, 3'b100, 4'h0, 7, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h2, 32'h1, 3'b100, 4'h0, 8, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h3, 32'h4, 3'b100, 4'h0, 9, -1, 1'b1);
    wait_response_done();
    applyStimulus(32'h3, 32'h4, 3'b100, 4'h0, 8, 3, 1'b1);
    wait_response_done();

    $display("[TB] sin traffic during a response");
    applyStimulus(32'h1000, 32'h0234, 3'b100, 4'h0, 8, -1, 1'b1);
    send_packet(PKT_DATA, 8'h5A, 1'b1);
    wait_response_done();
    applyStimulus(32'h55, 32'h0F, 3'b000, 4'h0, 8, -1, 1'b1);
    wait_response_done();

    $display("[TB] reset during a response");
    mon_en = 1'b0;
    applyStimulus(32'h2, 32'h1, 3'b100, 4'h0, 8, -1, 1'b0);
    k = last_stop_cyc;
    while (cyc < k + 2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("abort_started", 32'(bus.sout), 32'd0);
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      ok = ok && (bus.sout === 1'b1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      ok = ok && (bus.sout === 1'b1);
    end
    checkOutput("abort_idle", 32'(ok), 32'd1);
    mon_en = 1'b1;
    applyStimulus(32'hDEADBEEF, 32'h00000001, 3'b101, 4'h0, 8, -1, 1'b1);
    wait_response_done();

    $display("[TB] random frames");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 4) == 0) ? rb : $urandom;
      case ($urandom_range(0, 3))
        0:       rop = 3'b000;
        1:       rop = 3'b001;
        2:       rop = 3'b100;
        default: rop = 3'b101;
      endcase
      if ($urandom_range(0, 7) == 0) rop = 3'($urandom);
      rflip = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      applyStimulus(rb, ra, rop, rflip, 8, -1, 1'b1);
      wait_response_done();
    end

    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
